// File: rtl/wb_commit_pkg.sv
// Shared types and constants for the writeback stage and its pipe registers.
package wb_commit_pkg;

   localparam int WB_BITS      = 32;
   localparam int WB_REG_WORDS = 32;
   localparam int WB_CNT_BITS  = 32;

   localparam logic [3:0] BE_BYTE0 = 4'b0001;
   localparam logic [3:0] BE_BYTE1 = 4'b0010;
   localparam logic [3:0] BE_BYTE2 = 4'b0100;
   localparam logic [3:0] BE_BYTE3 = 4'b1000;
   localparam logic [3:0] BE_HALF0 = 4'b0011;
   localparam logic [3:0] BE_HALF1 = 4'b1100;
   localparam logic [3:0] BE_WORD  = 4'b1111;

   typedef enum logic {
      ST_RUN  = 1'b0,
      ST_HALT = 1'b1
   } wb_state_t;

endpackage

// File: rtl/wb_load_align.sv
// Load-lane alignment: selects and zero-extends the addressed byte/half/word.
module wb_load_align
   import wb_commit_pkg::*;
#(
   parameter int BITS = WB_BITS
) (
   input  logic [BITS-1:0] mem_rdata,
   input  logic [3:0]      byte_en,
   output logic [BITS-1:0] aligned
);

   always_comb begin
      aligned = mem_rdata;
      case (byte_en)
         BE_BYTE0: aligned = {{(BITS-8){1'b0}}, mem_rdata[7:0]};
         BE_BYTE1: aligned = {{(BITS-8){1'b0}}, mem_rdata[15:8]};
         BE_BYTE2: aligned = {{(BITS-8){1'b0}}, mem_rdata[23:16]};
         BE_BYTE3: aligned = {{(BITS-8){1'b0}}, mem_rdata[31:24]};
         BE_HALF0: aligned = {{(BITS-16){1'b0}}, mem_rdata[15:0]};
         BE_HALF1: aligned = {{(BITS-16){1'b0}}, mem_rdata[31:16]};
         default:  aligned = mem_rdata;
      endcase
   end

endmodule

// File: rtl/wb_commit.sv
// MEM/WB consumer: register-file write port, LL/SC reservation,
// sticky halt and commit counter.
module wb_commit
   import wb_commit_pkg::*;
#(
   parameter int BITS      = WB_BITS,
   parameter int REG_WORDS = WB_REG_WORDS,
   parameter int ADDR_LEFT = $clog2(REG_WORDS) - 1,
   parameter int CNT_BITS  = WB_CNT_BITS
) (
   input  logic                 clk,
   input  logic                 rst_,
   input  logic                 sel_mem_s5,
   input  logic                 rw_s5,
   input  logic [ADDR_LEFT:0]   waddr_s5,
   input  logic                 mem_rw_s5,
   input  logic                 load_link_s5,
   input  logic                 check_link_s5,
   input  logic                 atomic_s5,
   input  logic [3:0]           byte_en_s5,
   input  logic                 halt_s5,
   input  logic [BITS-1:0]      alu_out_s5,
   input  logic [BITS-1:0]      mem_rdata,
   output logic                 rf_we,
   output logic [ADDR_LEFT:0]   rf_waddr,
   output logic [BITS-1:0]      rf_wdata,
   output logic                 link_valid,
   output logic [BITS-1:0]      link_addr,
   output logic                 sc_success,
   output logic                 halted,
   output logic [CNT_BITS-1:0]  commit_cnt
);

   wb_state_t       state;
   logic [BITS-1:0] aligned;
   logic            is_ll;
   logic            is_sc;
   logic            word_hit;
   logic            store_hit;

   wb_load_align #(
      .BITS (BITS)
   ) u_align (
      .mem_rdata (mem_rdata),
      .byte_en   (byte_en_s5),
      .aligned   (aligned)
   );

   assign halted    = (state == ST_HALT);
   assign is_ll     = atomic_s5 & load_link_s5;
   assign is_sc     = atomic_s5 & check_link_s5;
   assign word_hit  = (link_addr[BITS-1:2] == alu_out_s5[BITS-1:2]);
   assign store_hit = mem_rw_s5 & ~check_link_s5 & link_valid & word_hit;

   assign sc_success = is_sc & link_valid & word_hit;
   assign rf_we      = rw_s5 & (|waddr_s5) & ~halted & ~halt_s5;
   assign rf_waddr   = waddr_s5;

   // SC reports its outcome in place of the memory word
   always_comb begin
      rf_wdata = alu_out_s5;
      priority case (1'b1)
         is_sc:      rf_wdata = {{(BITS-1){1'b0}}, sc_success};
         sel_mem_s5: rf_wdata = aligned;
         default:    rf_wdata = alu_out_s5;
      endcase
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         state <= ST_RUN;
      end else begin
         case (state)
            ST_RUN:  if (halt_s5) state <= ST_HALT;
            ST_HALT: state <= ST_HALT;
            default: state <= ST_RUN;
         endcase
      end
   end

   // LL wins over a simultaneous store flag
   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         link_valid <= 1'b0;
         link_addr  <= '0;
      end else if (!halted) begin
         if (is_ll) begin
            link_valid <= 1'b1;
            link_addr  <= {alu_out_s5[BITS-1:2], 2'b00};
         end else if (is_sc || store_hit) begin
            link_valid <= 1'b0;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_) begin
      if (!rst_) begin
         commit_cnt <= '0;
      end else if (rf_we) begin
         commit_cnt <= commit_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_wb_commit.sv
// Directed plus randomized checks of wb_commit against a spec-level model.
module tb_wb_commit;

   logic        clk = 1'b0;
   logic        rst_;
   logic        sel, rw, mrw, ll, cl, at, hl;
   logic [4:0]  wa;
   logic [3:0]  be;
   logic [31:0] alu, rd;

   logic        rf_we, link_valid, sc_success, halted;
   logic [4:0]  rf_waddr;
   logic [31:0] rf_wdata, link_addr, commit_cnt;

   logic        s_we, s_lv, s_sc, s_halted;
   logic [4:0]  s_waddr;
   logic [31:0] s_wdata, s_la;
   logic [3:0]  s_cnt;

   int errors = 0;
   int checks = 0;

   bit          m_lv;
   logic [31:0] m_la;
   bit          m_halt;
   logic [31:0] m_cnt;

   always #5 clk = ~clk;

   wb_commit dut (
      .clk(clk), .rst_(rst_), .sel_mem_s5(sel), .rw_s5(rw),
      .waddr_s5(wa), .mem_rw_s5(mrw), .load_link_s5(ll),
      .check_link_s5(cl), .atomic_s5(at), .byte_en_s5(be),
      .halt_s5(hl), .alu_out_s5(alu), .mem_rdata(rd),
      .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
      .link_valid(link_valid), .link_addr(link_addr),
      .sc_success(sc_success), .halted(halted),
      .commit_cnt(commit_cnt)
   );

   // narrow counter copy: exercises wrap-around in a few dozen writes
   wb_commit #(.CNT_BITS(4)) dut_w (
      .clk(clk), .rst_(rst_), .sel_mem_s5(sel), .rw_s5(rw),
      .waddr_s5(wa), .mem_rw_s5(mrw), .load_link_s5(ll),
      .check_link_s5(cl), .atomic_s5(at), .byte_en_s5(be),
      .halt_s5(hl), .alu_out_s5(alu), .mem_rdata(rd),
      .rf_we(s_we), .rf_waddr(s_waddr), .rf_wdata(s_wdata),
      .link_valid(s_lv), .link_addr(s_la),
      .sc_success(s_sc), .halted(s_halted),
      .commit_cnt(s_cnt)
   );

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] m_align(input logic [3:0] b,
                                           input logic [31:0] w);
      int lane;
      lane = -1;
      if (b == 4'b0001) lane = 0;
      if (b == 4'b0010) lane = 1;
      if (b == 4'b0100) lane = 2;
      if (b == 4'b1000) lane = 3;
      if (lane >= 0) return (w >> (8 * lane)) & 32'hFF;
      if (b == 4'b0011) return w & 32'hFFFF;
      if (b == 4'b1100) return w >> 16;
      return w;
   endfunction

   task automatic drv(input logic s, input logic r, input logic [4:0] w,
                      input logic m, input logic l, input logic c,
                      input logic a, input logic [3:0] b,
                      input logic h, input logic [31:0] al,
                      input logic [31:0] md);
      sel = s; rw = r; wa = w; mrw = m; ll = l; cl = c;
      at = a; be = b; hl = h; alu = al; rd = md;
   endtask

   task automatic idle();
      drv(0, 0, 0, 0, 0, 0, 0, 4'h0, 0, 0, 0);
   endtask

   task automatic m_reset();
      m_lv = 0; m_la = 0; m_halt = 0; m_cnt = 0;
   endtask

   // called at a negedge with inputs applied; ends at the next negedge
   task automatic step();
      bit          e_we, e_sc, hit;
      logic [31:0] e_wd;
      #1;
      hit  = m_lv && (m_la[31:2] == alu[31:2]);
      e_sc = at && cl && hit;
      e_we = rw && (wa != 0) && !m_halt && !hl;
      if (at && cl)  e_wd = {31'd0, e_sc};
      else if (sel)  e_wd = m_align(be, rd);
      else           e_wd = alu;
      chk("rf_we", {31'd0, rf_we}, {31'd0, e_we});
      chk("rf_waddr", {27'd0, rf_waddr}, {27'd0, wa});
      chk("rf_wdata", rf_wdata, e_wd);
      chk("sc_success", {31'd0, sc_success}, {31'd0, e_sc});
      if (!m_halt) begin
         if (at && ll) begin
            m_lv = 1;
            m_la = alu & ~32'h3;
         end else if (at && cl) begin
            m_lv = 0;
         end else if (mrw && !cl && hit) begin
            m_lv = 0;
         end
      end
      if (e_we) m_cnt = m_cnt + 1;
      if (hl) m_halt = 1;
      @(posedge clk);
      #1;
      chk("link_valid", {31'd0, link_valid}, {31'd0, m_lv});
      chk("link_addr", link_addr, m_la);
      chk("halted", {31'd0, halted}, {31'd0, m_halt});
      chk("commit_cnt", commit_cnt, m_cnt);
      chk("cnt_narrow", {28'd0, s_cnt}, {28'd0, m_cnt[3:0]});
      @(negedge clk);
   endtask

   task automatic do_reset_mid();
      #2;
      rst_ = 1'b0;
      idle();
      #1;
      m_reset();
      chk("rst_link_valid", {31'd0, link_valid}, 32'd0);
      chk("rst_link_addr", link_addr, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_cnt", commit_cnt, 32'd0);
      chk("rst_rf_we", {31'd0, rf_we}, 32'd0);
      chk("rst_rf_wdata", rf_wdata, 32'd0);
      @(negedge clk);
      rst_ = 1'b1;
   endtask

   logic [31:0] addrs [5];

   initial begin
      addrs = '{32'h100, 32'h101, 32'h104, 32'h200, 32'h203};
      rst_ = 1'b0;
      idle();
      m_reset();
      repeat (2) @(negedge clk);
      rst_ = 1'b1;

      // some traffic, then reset asserted mid-cycle
      drv(0, 1, 3, 0, 0, 0, 0, 4'h0, 0, 32'h55, 0); step();
      drv(1, 1, 0, 0, 1, 0, 1, 4'hF, 0, 32'h100, 32'h9); step();
      do_reset_mid();

      drv(0, 1, 5, 0, 0, 0, 0, 4'h0, 0, 32'h1234, 0);
      #1;
      chk("w5_we", {31'd0, rf_we}, 32'd1);
      chk("w5_data", rf_wdata, 32'h1234);
      step();
      chk("w5_cnt", commit_cnt, 32'd1);
      drv(0, 1, 0, 0, 0, 0, 0, 4'h0, 0, 32'h1234, 0);
      step();
      chk("r0_cnt", commit_cnt, 32'd1);

      // lane sweep
      drv(1, 1, 2, 0, 0, 0, 0, 4'b0001, 0, 0, 32'hAABBCCDD); step();
      drv(1, 1, 2, 0, 0, 0, 0, 4'b0100, 0, 0, 32'hAABBCCDD); step();
      drv(1, 1, 2, 0, 0, 0, 0, 4'b1100, 0, 0, 32'hAABBCCDD); step();
      drv(1, 1, 2, 0, 0, 0, 0, 4'b0011, 0, 0, 32'hAABBCCDD); step();
      drv(1, 1, 2, 0, 0, 0, 0, 4'b1111, 0, 0, 32'hAABBCCDD); step();
      drv(1, 1, 2, 0, 0, 0, 0, 4'b0010, 0, 0, 32'hAABBCCDD); step();
      drv(1, 1, 2, 0, 0, 0, 0, 4'b0101, 0, 0, 32'hAABBCCDD); step();

      // LL / SC pair, then a stale SC
      drv(1, 1, 6, 0, 1, 0, 1, 4'hF, 0, 32'h100, 32'h77); step();
      drv(0, 1, 7, 1, 0, 1, 1, 4'hF, 0, 32'h103, 0);
      #1;
      chk("sc1_ok", {31'd0, sc_success}, 32'd1);
      chk("sc1_data", rf_wdata, 32'd1);
      step();
      chk("sc1_link", {31'd0, link_valid}, 32'd0);
      drv(0, 1, 7, 1, 0, 1, 1, 4'hF, 0, 32'h103, 0);
      #1;
      chk("sc2_data", rf_wdata, 32'd0);
      step();

      // stores near and on the reserved word
      drv(1, 1, 6, 0, 1, 0, 1, 4'hF, 0, 32'h100, 32'h77); step();
      drv(0, 0, 0, 1, 0, 0, 0, 4'hF, 0, 32'h200, 0); step();
      chk("st_other_link", {31'd0, link_valid}, 32'd1);
      drv(0, 0, 0, 1, 0, 0, 0, 4'hF, 0, 32'h100, 0); step();
      chk("st_hit_link", {31'd0, link_valid}, 32'd0);
      drv(0, 1, 7, 1, 0, 1, 1, 4'hF, 0, 32'h100, 0);
      #1;
      chk("sc3_data", rf_wdata, 32'd0);
      step();

      // randomized traffic
      for (int i = 0; i < 400; i++) begin
         logic [31:0] a;
         logic [4:0]  w;
         a = addrs[$urandom_range(0, 4)];
         w = 5'($urandom_range(0, 31));
         case ($urandom_range(0, 6))
            0: idle();
            1: drv(0, 1, w, 0, 0, 0, 0, 4'h0, 0, $urandom, $urandom);
            2: drv(1, 1, w, 0, 0, 0, 0, 4'($urandom), 0, a, $urandom);
            3: drv(1, 1, w, 0, 1, 0, 1, 4'hF, 0, a, $urandom);
            4: drv(0, 1, w, 1, 0, 1, 1, 4'hF, 0, a, $urandom);
            5: drv(0, 0, w, 1, 0, 0, 0, 4'hF, 0, a, $urandom);
            default: drv(1, 1, w, $urandom_range(0, 1), 1'($urandom),
                         1'($urandom), 0, 4'($urandom), 0, a, $urandom);
         endcase
         step();
      end

      // halt: freezes writes, reservation and count
      drv(1, 1, 6, 0, 1, 0, 1, 4'hF, 0, 32'h100, 32'h1); step();
      drv(0, 1, 3, 0, 0, 0, 0, 4'h0, 1, 32'hDEAD, 0);
      #1;
      chk("halt_we", {31'd0, rf_we}, 32'd0);
      step();
      chk("halt_set", {31'd0, halted}, 32'd1);
      drv(0, 1, 4, 0, 0, 0, 0, 4'h0, 0, 32'h42, 0); step();
      drv(0, 0, 0, 1, 0, 0, 0, 4'hF, 0, 32'h100, 0); step();
      chk("halt_link_kept", {31'd0, link_valid}, 32'd1);
      drv(1, 1, 6, 0, 1, 0, 1, 4'hF, 0, 32'h300, 32'h1); step();
      chk("halt_link_addr", link_addr, 32'h100);
      idle();
      do_reset_mid();
      drv(0, 1, 9, 0, 0, 0, 0, 4'h0, 0, 32'h99, 0); step();
      chk("post_halt_cnt", commit_cnt, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
